// File: rtl/riscv_mdseq_pkg.sv
// rtl/riscv_mdseq_pkg.sv - shared constants and types for the mul/div sequencer
package riscv_mdseq_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int MDSEQ_MAXCYC = 70;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } md_op_e;

endpackage

// File: rtl/riscv_mdseq_wdog.sv
// rtl/riscv_mdseq_wdog.sv - saturating BUSY-cycle counter with terminal-count flag
module riscv_mdseq_wdog
    import riscv_mdseq_pkg::*;
#(
    parameter int MAXCYC = MDSEQ_MAXCYC
) (
    input  logic clk_i,
    input  logic resetn_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int CW = $clog2(MAXCYC + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAXCYC);
    localparam logic [CW-1:0] CNT_TC  = CW'(MAXCYC - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == CNT_TC);

endmodule

// File: rtl/riscv_mdseq.sv
// rtl/riscv_mdseq.sv - start/stall/capture sequencer for the iterative mul/div units
module riscv_mdseq
    import riscv_mdseq_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int MAXCYC = MDSEQ_MAXCYC
) (
    input  logic            i_riscv_mdseq_clk,
    input  logic            i_riscv_mdseq_rst,
    input  logic            i_riscv_mdseq_mul_en,
    input  logic            i_riscv_mdseq_div_en,
    input  logic            i_riscv_mdseq_globstall,
    input  logic            i_riscv_mdseq_flush,
    input  logic            i_riscv_mdseq_unit_valid,
    input  logic [XLEN-1:0] i_riscv_mdseq_unit_result,
    output logic            o_riscv_mdseq_mul_start,
    output logic            o_riscv_mdseq_div_start,
    output logic            o_riscv_mdseq_kill,
    output logic            o_riscv_mdseq_stall,
    output logic [XLEN-1:0] o_riscv_mdseq_result,
    output logic            o_riscv_mdseq_result_valid,
    output logic            o_riscv_mdseq_timeout
);

    logic [1:0]      state_q, state_d;
    md_op_e          op_q, op_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            timeout_q, timeout_d;
    logic            mul_start, div_start, kill, stall, to_now;
    logic            req, wd_run, wd_tc;

    assign req = i_riscv_mdseq_mul_en | i_riscv_mdseq_div_en;

    // Counter reads N in BUSY cycle N: cleared whenever the next state is not BUSY.
    assign wd_run = (state_d == ST_BUSY);

    riscv_mdseq_wdog #(
        .MAXCYC(MAXCYC)
    ) u_wdog (
        .clk_i   (i_riscv_mdseq_clk),
        .resetn_i(i_riscv_mdseq_rst),
        .clr_i   (!wd_run),
        .en_i    (wd_run),
        .tc_o    (wd_tc)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        result_d  = result_q;
        timeout_d = timeout_q;
        mul_start = 1'b0;
        div_start = 1'b0;
        kill      = 1'b0;
        stall     = 1'b0;
        to_now    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_riscv_mdseq_rst && req && !i_riscv_mdseq_flush) begin
                    mul_start = i_riscv_mdseq_mul_en;
                    div_start = !i_riscv_mdseq_mul_en;
                    stall     = 1'b1;
                    op_d      = i_riscv_mdseq_mul_en ? OP_MUL : OP_DIV;
                    state_d   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                stall = 1'b1;
                if (i_riscv_mdseq_flush) begin
                    kill    = 1'b1;
                    state_d = ST_IDLE;
                end else if (i_riscv_mdseq_unit_valid) begin
                    result_d = i_riscv_mdseq_unit_result;
                    state_d  = ST_DONE;
                end else if (wd_tc) begin
                    kill      = 1'b1;
                    to_now    = 1'b1;
                    timeout_d = 1'b1;
                    result_d  = '1;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                if (i_riscv_mdseq_flush || !i_riscv_mdseq_globstall) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_riscv_mdseq_clk) begin
        if (!i_riscv_mdseq_rst) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_MUL;
            result_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            result_q  <= result_d;
            timeout_q <= timeout_d;
        end
    end

    // The EX instruction is frozen while its unit iterates, so its enable must hold.
    always @(posedge i_riscv_mdseq_clk) begin
        if (i_riscv_mdseq_rst && state_q == ST_BUSY) begin
            assert (op_q == OP_MUL ? i_riscv_mdseq_mul_en : i_riscv_mdseq_div_en);
        end
    end

    assign o_riscv_mdseq_mul_start    = mul_start;
    assign o_riscv_mdseq_div_start    = div_start;
    assign o_riscv_mdseq_kill         = kill & i_riscv_mdseq_rst;
    assign o_riscv_mdseq_stall        = stall;
    assign o_riscv_mdseq_result       = result_q;
    assign o_riscv_mdseq_result_valid = (state_q == ST_DONE);
    assign o_riscv_mdseq_timeout      = timeout_q | (to_now & i_riscv_mdseq_rst);

endmodule
